// File: rtl/a23_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : a23_cache_pkg
// Purpose  : Shared definitions for the Amber 23 cache control blocks:
//            flush sequencer state encoding, 2MB region address fields and
//            default cache geometry.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package a23_cache_pkg;

    // Flush sequencer states (explicit 2-bit encoding)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } flush_state_t;

    // A region is 2MB: address bits [25:21] select one of 32 regions, and
    // only the low 64MB (bits [31:26] all zero) is covered by the flag word.
    localparam int REGION_LSB       = 21;
    localparam int REGION_W         = 5;
    localparam int REGION_LIMIT_MSB = 26;

    // Default cache geometry
    localparam int DEFAULT_SETS  = 256;
    localparam int DEFAULT_SET_W = 8;
    localparam int DEFAULT_WAYS  = 4;

endpackage : a23_cache_pkg
`default_nettype wire

// File: rtl/a23_region_decode.sv
`default_nettype none
// ============================================================================
// Module   : a23_region_decode
// Purpose  : Splits a core address into a 2MB region index and a flag saying
//            whether the address lies inside the 64MB window that the
//            per-region flag registers describe. Shared by the disruptive-area
//            check and the cacheable-area check.
// Ports    : i_address  [31:0]         byte address
//            o_region   [REGION_W-1:0] region index (address bits [25:21])
//            o_in_range                address below 64MB
// Revision : 1.0 - initial release
// ============================================================================
module a23_region_decode
    import a23_cache_pkg::*;
(
    input  logic [31:0]         i_address,
    output logic [REGION_W-1:0] o_region,
    output logic                o_in_range
);

    // Offset within the region is irrelevant to region decoding.
    logic w_unused_offset;
    assign w_unused_offset = ^i_address[REGION_LSB-1:0];

    assign o_region   = i_address[REGION_LSB +: REGION_W];
    assign o_in_range = (i_address[31:REGION_LIMIT_MSB] == '0);

endmodule : a23_region_decode
`default_nettype wire

// File: rtl/a23_cache_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : a23_cache_flush_ctrl
// Purpose  : Sequences invalidation of the cache tag RAM. A sweep starts on a
//            CP15 flush pulse, on a core write into a disruptive 2MB region,
//            or on reset release, and writes an invalid tag to every way of
//            every set while holding the core stalled.
// Ports    : i_clk              core clock
//            i_rst_n            synchronous active-low reset
//            i_fetch_stall      global pipeline stall (masks core writes)
//            i_cache_enable     CP15 cache_control bit 0
//            i_cache_flush      one-cycle flush request
//            i_disruptive_area  per-2MB-region disruptive flags
//            i_core_write       core data write this cycle
//            i_core_address     core write address
//            o_flush_busy       sweep in progress, core must stall
//            o_tag_wr_en        tag RAM write enables (all ways)
//            o_tag_wr_addr      set index being invalidated
//            o_flush_done       one-cycle pulse after a complete sweep
//            o_cache_enable_eff cache enable gated by sweep activity
// Revision : 1.0 - initial release
// ============================================================================
module a23_cache_flush_ctrl
    import a23_cache_pkg::*;
#(
    parameter int SETS  = DEFAULT_SETS,
    parameter int SET_W = DEFAULT_SET_W,
    parameter int WAYS  = DEFAULT_WAYS
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_fetch_stall,
    input  logic             i_cache_enable,
    input  logic             i_cache_flush,
    input  logic [31:0]      i_disruptive_area,
    input  logic             i_core_write,
    input  logic [31:0]      i_core_address,
    output logic             o_flush_busy,
    output logic [WAYS-1:0]  o_tag_wr_en,
    output logic [SET_W-1:0] o_tag_wr_addr,
    output logic             o_flush_done,
    output logic             o_cache_enable_eff
);

    localparam logic [SET_W-1:0] c_LAST_SET = SET_W'(SETS - 1);

    flush_state_t     r_state;
    logic [SET_W-1:0] r_count;
    logic             r_busy;
    logic [WAYS-1:0]  r_wr_en;
    logic             r_done;
    logic             r_init_pending;

    logic [REGION_W-1:0] w_region;
    logic                w_in_range;
    logic                w_disruptive_hit;
    logic                w_req;

    a23_region_decode u_region_decode (
        .i_address  (i_core_address),
        .o_region   (w_region),
        .o_in_range (w_in_range)
    );

    // A stalled write has not really happened yet, so it must not trigger.
    assign w_disruptive_hit = i_core_write & ~i_fetch_stall & i_cache_enable &
                              w_in_range & i_disruptive_area[w_region];

    // All sources collapse into one request, so coincident sources cost
    // exactly one sweep.
    assign w_req = r_init_pending | i_cache_flush | w_disruptive_hit;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state        <= ST_IDLE;
            r_count        <= '0;
            r_busy         <= 1'b0;
            r_wr_en        <= '0;
            r_done         <= 1'b0;
            r_init_pending <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_req) begin
                        r_state        <= ST_SWEEP;
                        r_count        <= '0;
                        r_busy         <= 1'b1;
                        r_wr_en        <= '1;
                        r_init_pending <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SWEEP: begin
                    if (w_req) begin
                        // Tags already cleared may have been refilled, so
                        // the whole sweep starts over.
                        r_count        <= '0;
                        r_init_pending <= 1'b0;
                    end else if (r_count == c_LAST_SET) begin
                        r_state <= ST_DONE;
                        r_count <= '0;
                        r_busy  <= 1'b0;
                        r_wr_en <= '0;
                        r_done  <= 1'b1;
                    end else begin
                        r_count <= r_count + SET_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_count <= '0;
                    r_busy  <= 1'b0;
                    r_wr_en <= '0;
                end
            endcase
        end
    end

    assign o_flush_busy       = r_busy;
    assign o_tag_wr_en        = r_wr_en;
    assign o_tag_wr_addr      = r_count;
    assign o_flush_done       = r_done;
    // Gate lookups the moment a sweep is visible so stale tags never hit.
    assign o_cache_enable_eff = i_cache_enable & ~r_busy;

endmodule : a23_cache_flush_ctrl
`default_nettype wire

// File: tb/tb_a23_cache_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_a23_cache_flush_ctrl
// Purpose  : Directed self-checking bench for a23_cache_flush_ctrl.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_a23_cache_flush_ctrl;

    logic        clk;
    logic        rst_n;
    logic        fetch_stall;
    logic        cache_enable;
    logic        cache_flush;
    logic [31:0] disruptive_area;
    logic        core_write;
    logic [31:0] core_address;
    logic        flush_busy;
    logic [3:0]  tag_wr_en;
    logic [7:0]  tag_wr_addr;
    logic        flush_done;
    logic        cache_enable_eff;

    int n_checks = 0;
    int n_pass   = 0;

    // {busy, wr_en, addr, done}
    logic [13:0] obs;
    assign obs = {flush_busy, tag_wr_en, tag_wr_addr, flush_done};

    localparam logic [13:0] c_IDLE = 14'h0000;
    localparam logic [13:0] c_DONE = 14'h0001;

    a23_cache_flush_ctrl #(.SETS(256), .SET_W(8), .WAYS(4)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_fetch_stall      (fetch_stall),
        .i_cache_enable     (cache_enable),
        .i_cache_flush      (cache_flush),
        .i_disruptive_area  (disruptive_area),
        .i_core_write       (core_write),
        .i_core_address     (core_address),
        .o_flush_busy       (flush_busy),
        .o_tag_wr_en        (tag_wr_en),
        .o_tag_wr_addr      (tag_wr_addr),
        .o_flush_done       (flush_done),
        .o_cache_enable_eff (cache_enable_eff)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge; inputs driven here are sampled next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_checks++;
        if (obs !== c_IDLE) $display("FAIL reset_outputs: got %h want %h", obs, c_IDLE);
        else n_pass++;
        n_checks++;
        if (cache_enable_eff !== 1'b1) $display("FAIL reset_eff: got %b want 1", cache_enable_eff);
        else n_pass++;
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 256; k++) begin
            n_checks++;
            if (obs !== {1'b1, 4'hF, k[7:0], 1'b0})
                $display("FAIL init_sweep[%0d]: got %h want %h", k, obs, {1'b1, 4'hF, k[7:0], 1'b0});
            else n_pass++;
            step();
        end
        n_checks++;
        if (obs !== c_DONE) $display("FAIL init_done: got %h want %h", obs, c_DONE);
        else n_pass++;
        step();
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (obs !== c_IDLE) $display("FAIL init_idle[%0d]: got %h want %h", k, obs, c_IDLE);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_flush();
        cache_flush = 1'b1;
        step();
        cache_flush = 1'b0;
        for (int k = 0; k < 256; k++) begin
            n_checks++;
            if ({obs, cache_enable_eff} !== {1'b1, 4'hF, k[7:0], 1'b0, 1'b0})
                $display("FAIL flush_sweep[%0d]: got %h/%b want %h/0", k, obs, cache_enable_eff,
                         {1'b1, 4'hF, k[7:0], 1'b0});
            else n_pass++;
            step();
        end
        n_checks++;
        if ({obs, cache_enable_eff} !== {c_DONE, 1'b1})
            $display("FAIL flush_done: got %h/%b want %h/1", obs, cache_enable_eff, c_DONE);
        else n_pass++;
        step();
        n_checks++;
        if (obs !== c_IDLE) $display("FAIL flush_idle: got %h want %h", obs, c_IDLE);
        else n_pass++;
    endtask

    task automatic test_disruptive();
        logic [31:0] addrs [3];
        logic        stalls [3];
        addrs[0] = 32'h0440_0010; stalls[0] = 1'b0;  // above 64MB
        addrs[1] = 32'h0040_0010; stalls[1] = 1'b1;  // stalled write
        addrs[2] = 32'h0060_0010; stalls[2] = 1'b0;  // unflagged region 3
        disruptive_area = 32'h0000_0004;
        for (int i = 0; i < 3; i++) begin
            core_address = addrs[i];
            fetch_stall  = stalls[i];
            core_write   = 1'b1;
            step();
            core_write  = 1'b0;
            fetch_stall = 1'b0;
            step();
            n_checks++;
            if (obs !== c_IDLE) $display("FAIL disr_nohit[%0d]: got %h want %h", i, obs, c_IDLE);
            else n_pass++;
        end
        core_address = 32'h0040_0010;
        core_write   = 1'b1;
        step();
        core_write = 1'b0;
        for (int k = 0; k < 256; k++) begin
            n_checks++;
            if (obs !== {1'b1, 4'hF, k[7:0], 1'b0})
                $display("FAIL disr_sweep[%0d]: got %h want %h", k, obs, {1'b1, 4'hF, k[7:0], 1'b0});
            else n_pass++;
            step();
        end
        n_checks++;
        if (obs !== c_DONE) $display("FAIL disr_done: got %h want %h", obs, c_DONE);
        else n_pass++;
        step();
    endtask

    task automatic test_restart();
        int busy_cnt = 0;
        int done_cnt = 0;
        cache_flush = 1'b1;
        step();
        cache_flush = 1'b0;
        for (int k = 0; k <= 100; k++) begin
            n_checks++;
            if (obs !== {1'b1, 4'hF, k[7:0], 1'b0})
                $display("FAIL restart_pre[%0d]: got %h want %h", k, obs, {1'b1, 4'hF, k[7:0], 1'b0});
            else n_pass++;
            busy_cnt += int'(flush_busy);
            if (k == 100) cache_flush = 1'b1;
            step();
        end
        cache_flush = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (k < 256) begin
                n_checks++;
                if (tag_wr_addr !== k[7:0])
                    $display("FAIL restart_addr[%0d]: got %h want %h", k, tag_wr_addr, k[7:0]);
                else n_pass++;
            end
            busy_cnt += int'(flush_busy);
            done_cnt += int'(flush_done);
            step();
        end
        n_checks++;
        if (busy_cnt !== 357) $display("FAIL restart_busy_cycles: got %0d want 357", busy_cnt);
        else n_pass++;
        n_checks++;
        if (done_cnt !== 1) $display("FAIL restart_done_count: got %0d want 1", done_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        cache_flush = 1'b1;
        step();
        cache_flush = 1'b0;
        for (int k = 0; k < 50; k++) step();
        n_checks++;
        if (obs !== {1'b1, 4'hF, 8'd50, 1'b0}) $display("FAIL rstmid_at50: got %h want %h", obs, {1'b1, 4'hF, 8'd50, 1'b0});
        else n_pass++;
        rst_n = 1'b0;
        step();
        n_checks++;
        if (obs !== c_IDLE) $display("FAIL rstmid_zero: got %h want %h", obs, c_IDLE);
        else n_pass++;
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 256; k++) begin
            n_checks++;
            if (obs !== {1'b1, 4'hF, k[7:0], 1'b0})
                $display("FAIL rstmid_sweep[%0d]: got %h want %h", k, obs, {1'b1, 4'hF, k[7:0], 1'b0});
            else n_pass++;
            step();
        end
        n_checks++;
        if (obs !== c_DONE) $display("FAIL rstmid_done: got %h want %h", obs, c_DONE);
        else n_pass++;
        step();
    endtask

    task automatic test_coincident();
        int busy_cnt = 0;
        int done_cnt = 0;
        disruptive_area = 32'h0000_0004;
        core_address    = 32'h0040_0010;
        core_write      = 1'b1;
        cache_flush     = 1'b1;
        step();
        core_write  = 1'b0;
        cache_flush = 1'b0;
        for (int k = 0; k < 300; k++) begin
            busy_cnt += int'(flush_busy);
            done_cnt += int'(flush_done);
            step();
        end
        n_checks++;
        if (busy_cnt !== 256) $display("FAIL coinc_busy_cycles: got %0d want 256", busy_cnt);
        else n_pass++;
        n_checks++;
        if (done_cnt !== 1) $display("FAIL coinc_done_count: got %0d want 1", done_cnt);
        else n_pass++;
    endtask

    // A request arriving in the DONE cycle starts a new sweep immediately.
    task automatic test_back_to_back();
        cache_flush = 1'b1;
        step();
        cache_flush = 1'b0;
        for (int k = 0; k < 256; k++) step();
        n_checks++;
        if (obs !== c_DONE) $display("FAIL b2b_done: got %h want %h", obs, c_DONE);
        else n_pass++;
        cache_flush = 1'b1;
        step();
        cache_flush = 1'b0;
        n_checks++;
        if (obs !== {1'b1, 4'hF, 8'd0, 1'b0}) $display("FAIL b2b_restart: got %h want %h", obs, {1'b1, 4'hF, 8'd0, 1'b0});
        else n_pass++;
        for (int k = 0; k < 256; k++) step();
        n_checks++;
        if (obs !== c_DONE) $display("FAIL b2b_done2: got %h want %h", obs, c_DONE);
        else n_pass++;
        step();
        n_checks++;
        if (obs !== c_IDLE) $display("FAIL b2b_idle: got %h want %h", obs, c_IDLE);
        else n_pass++;
    endtask

    initial begin
        rst_n           = 1'b0;
        fetch_stall     = 1'b0;
        cache_enable    = 1'b1;
        cache_flush     = 1'b0;
        disruptive_area = 32'h0;
        core_write      = 1'b0;
        core_address    = 32'h0;

        test_reset();
        test_flush();
        test_disruptive();
        test_restart();
        test_reset_mid();
        test_coincident();
        test_back_to_back();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_a23_cache_flush_ctrl
`default_nettype wire

// File: doc/a23_cache_flush_ctrl.md
Name: a23_cache_flush_ctrl

Overview:
- Sequences invalidation of the Amber 23 cache tag RAM.
- Starts a sweep on: a flush pulse from coprocessor 15 (write to CP15 register 1); a core write that hits a 2MB region flagged in the disruptive-area register; or reset release.
- Walks every set, writing an invalid tag into all ways, and holds the core stalled until the sweep completes.
- Sits between the coprocessor 15 register block, the core write path and the cache tag RAM write port.

Parameters:
- SETS, 256, number of cache sets to invalidate (power of two).
- SET_W, 8, set index width (log2 SETS).
- WAYS, 4, number of ways, all written in parallel.

Ports:
- i_clk  input  1  core clock
- i_rst_n  input  1  synchronous active-low reset
- i_fetch_stall  input  1  global pipeline stall; core write qualification is ignored while high
- i_cache_enable  input  1  cache_control bit 0 from CP15
- i_cache_flush  input  1  one-cycle flush request (CP15 register 1 write)
- i_disruptive_area  input  32  per-2MB-region disruptive flags from CP15 register 5
- i_core_write  input  1  core data write in the current cycle
- i_core_address  input  32  core write address
- o_flush_busy  output  1  sweep in progress; core must stall
- o_tag_wr_en  output  WAYS  tag RAM write enables, all ones during a sweep
- o_tag_wr_addr  output  SET_W  set index being invalidated
- o_flush_done  output  1  one-cycle pulse after a complete sweep
- o_cache_enable_eff  output  1  i_cache_enable AND NOT o_flush_busy

Behaviour:
- Reset (i_rst_n low at a clock edge):
  - state=IDLE, counter=0.
  - o_flush_busy=0, o_tag_wr_en=0, o_tag_wr_addr=0, o_flush_done=0.
  - An init-pending flag is set.
- States: IDLE, SWEEP, DONE.
- Request condition req:
  - init-pending, OR i_cache_flush, OR disruptive hit.
  - Disruptive hit = i_core_write AND NOT i_fetch_stall AND i_cache_enable AND i_core_address[31:26]==0 AND i_disruptive_area[i_core_address[25:21]].
  - Addresses at or above 64MB are never disruptive.
- IDLE: if req at edge N, then at N+1: SWEEP, counter=0, busy=1, init-pending cleared.
- SWEEP:
  - Each cycle drives o_tag_wr_en=all ones and o_tag_wr_addr=counter, then increments counter.
  - When counter==SETS-1, the next state is DONE.
  - Tag writes are registered outputs: set k is written in cycle N+1+k.
- DONE:
  - One cycle: o_flush_done=1, busy=0, tag_wr_en=0; then IDLE.
  - A new request in DONE re-enters SWEEP at the next edge.
- Latency: a request at edge N produces busy=1 for cycles N+1..N+SETS and done at N+SETS+1.
- Request during SWEEP:
  - counter restarts at 0 on the next edge.
  - No done pulse until one uninterrupted full sweep finishes.
- Simultaneous flush pulse and disruptive hit: treated as a single request.
- i_fetch_stall does not pause the sweep; the sweep itself is the stall source.
- Counter wraps only via the DONE transition. Never write set indices at or above SETS.
- o_cache_enable_eff is combinational: it is low while busy so no lookup hits stale tags.
- Reset mid-sweep:
  - Outputs return to their reset values at the next edge.
  - A full sweep restarts after reset is released.

Decomposition:
- Package a23_cache_pkg:
  - State encoding constants.
  - REGION_LSB=21, REGION_W=5, REGION_LIMIT_MSB=26.
  - Default SETS and WAYS values.
- Sub-module a23_region_decode (address -> region index + in-range flag), reused by the cacheable-area check in the cache.

Test Plan:
- Reset release with SETS=256: busy high for cycles 1..256, o_tag_wr_addr sequence 0..255, o_flush_done pulses at cycle 257, then IDLE.
- i_cache_flush pulse in IDLE at edge 10: tag writes at cycles 11..266, done at 267; o_cache_enable_eff=0 throughout with i_cache_enable=1.
- Disruptive write: i_disruptive_area=0x00000004, write to address 0x00400010 -> sweep starts. Write to 0x04400010 (above 64MB) or with i_fetch_stall=1 -> no sweep.
- Flush pulse at sweep set 100 -> o_tag_wr_addr returns to 0 next cycle, exactly one done pulse after the restarted full sweep (total busy = 101+256 cycles).
- i_rst_n low for one cycle at set 50 -> outputs zeroed next edge, then a fresh 0..255 sweep after release.
- Flush pulse coincident with a disruptive hit in IDLE -> single sweep, single done pulse.
